// File: rtl/jzjpcc_uart_pkg.sv
// jzjpcc_uart_pkg: shared FSM state type and MMIO field positions for the
// jzjpcc UART transmitter. Optional parity build: JZJPCC_UART_TX_PARITY_EN.
package jzjpcc_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef JZJPCC_UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_tx_state_t;

    // command register fields
    localparam int CMD_DATA_MSB = 7;
    localparam int CMD_TOGGLE_B = 8;

    // status register fields
    localparam int STAT_BUSY_B    = 0;
    localparam int STAT_FULL_B    = 1;
    localparam int STAT_ACK_B     = 8;
    localparam int STAT_COUNT_LSB = 16;

endpackage

// File: rtl/jzjpcc_uart_fifo.sv
// jzjpcc_uart_fifo: synchronous FIFO with registered occupancy count.
// Ports: clock/reset (async high), push/wdata, pop/rdata, full, empty, count.
module jzjpcc_uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    // full/empty come from the registered count, so a push at a full count
    // is refused even if a pop frees a slot on the same edge
    assign full    = (count == (PW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // storage needs no reset; pointers define what is valid
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/jzjpcc_mmio_uart_tx.sv
// jzjpcc_mmio_uart_tx: toggle-handshake MMIO UART transmitter with byte FIFO.
// Ports: clock, reset (async high), command (MMIO out word), status (MMIO in
// word), txd (serial line). Parity build: JZJPCC_UART_TX_PARITY_EN (8E1).
module jzjpcc_mmio_uart_tx
    import jzjpcc_uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 434,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] command,
    output logic [31:0] status,
    output logic        txd
);

    localparam int BW = $clog2(CLOCKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BIT - 1);

    uart_tx_state_t state;
    logic [BW-1:0]  baud;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           ack;
    logic           push;
    logic           pop;
    logic           baud_done;
    logic [7:0]     fifo_data;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           cmd_unused;
`ifdef JZJPCC_UART_TX_PARITY_EN
    logic           parity;
`endif

    assign cmd_unused = ^command[31:CMD_TOGGLE_B+1];

    // ack doubles as the last-seen request toggle
    assign push      = (command[CMD_TOGGLE_B] != ack) & ~fifo_full;
    assign pop       = (state == ST_IDLE) & ~fifo_empty;
    assign baud_done = (baud == BAUD_LAST);

    jzjpcc_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (command[CMD_DATA_MSB:0]),
        .pop   (pop),
        .rdata (fifo_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack <= 1'b0;
        end else if (push) begin
            ack <= command[CMD_TOGGLE_B];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
`ifdef JZJPCC_UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shift   <= fifo_data;
                        baud    <= '0;
                        bit_idx <= '0;
                        txd     <= 1'b0;
                        state   <= ST_START;
`ifdef JZJPCC_UART_TX_PARITY_EN
                        parity  <= ^fifo_data;
`endif
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        baud  <= '0;
                        txd   <= shift[0];
                        state <= ST_DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef JZJPCC_UART_TX_PARITY_EN
                            txd   <= parity;
                            state <= ST_PARITY;
`else
                            txd   <= 1'b1;
                            state <= ST_STOP;
`endif
                        end else begin
                            // txd takes the next bit as the shift happens
                            shift   <= shift >> 1;
                            txd     <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`ifdef JZJPCC_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_done) begin
                        baud  <= '0;
                        txd   <= 1'b1;
                        state <= ST_STOP;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_done) begin
                        baud  <= '0;
                        state <= ST_IDLE;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        status = '0;
        status[STAT_BUSY_B] = (state != ST_IDLE) | (fifo_count != '0);
        status[STAT_FULL_B] = fifo_full;
        status[STAT_ACK_B]  = ack;
        status[STAT_COUNT_LSB +: 8] = 8'(fifo_count);
    end

endmodule

// File: tb/tb_jzjpcc_mmio_uart_tx.sv
// tb_jzjpcc_mmio_uart_tx: self-checking bench for the MMIO UART transmitter.
// A line decoder rebuilds frames from txd and is compared with expected bytes.
module tb_jzjpcc_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef JZJPCC_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FLEN = NB * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] command = '0;
    logic [31:0] status;
    logic        txd;

    int tests = 0;
    int fails = 0;
    logic tog = 1'b0;

    jzjpcc_mmio_uart_tx #(
        .CLOCKS_PER_BIT (CPB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .command (command),
        .status  (status),
        .txd     (txd)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- line decoder ----------------
    logic [7:0] rx_q[$];
    int         gap_q[$];
    logic       samp [FLEN];
    int         fpos = -1;
    int         cyc = 0;
    int         last_end = -100;

    task automatic check_frame();
        logic [NB-1:0] bits;
        logic [7:0]    b;
        logic          ok = 1'b1;
        for (int i = 0; i < NB; i++) begin
            bits[i] = samp[i*CPB];
            for (int j = 1; j < CPB; j++)
                if (samp[i*CPB+j] !== bits[i]) ok = 1'b0;
        end
        b = bits[8:1];
        if (bits[0] !== 1'b0) ok = 1'b0;
        if (bits[NB-1] !== 1'b1) ok = 1'b0;
`ifdef JZJPCC_UART_TX_PARITY_EN
        if (bits[9] !== ^b) ok = 1'b0;
`endif
        chk("frame_shape", 32'(ok), 32'd1);
        rx_q.push_back(b);
    endtask

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            fpos = -1;
        end else if (fpos < 0) begin
            if (txd === 1'b0) begin
                gap_q.push_back(cyc - last_end - 1);
                samp[0] = 1'b0;
                fpos = 1;
            end
        end else begin
            samp[fpos] = txd;
            fpos++;
            if (fpos == FLEN) begin
                check_frame();
                last_end = cyc;
                fpos = -1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic [22:0] up,
                             output int n);
        tog = ~tog;
        command = {up, tog, d};
        n = 0;
        do begin
            tick();
            n++;
        end while (status[8] !== tog && n < 400);
        if (status[8] !== tog) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: ack %0b, required %0b", status[8], tog);
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (status[0] !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        if (status[0] !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: busy 1 after %0d cycles, required 0", n);
        end
    endtask

    typedef struct {
        logic [31:0] cmd;
        logic        send;
        logic [7:0]  data;
        logic [31:0] st_ack;
        logic [31:0] st_pop;
    } vec_t;

    initial begin
        vec_t       vt[7];
        int         n;
        int         bad;
        int         waits[6];
        logic [31:0] st[6];
        logic [7:0] exp_q[$];
        logic [7:0] d;
        logic [31:0] up;

        vt[0] = '{32'h0000_0155, 1'b1, 8'h55, 32'h0001_0101, 32'h0000_0101};
        vt[1] = '{32'h0000_0155, 1'b0, 8'h00, 32'h0000_0100, 32'h0000_0100};
        vt[2] = '{32'h0000_00A3, 1'b1, 8'hA3, 32'h0001_0001, 32'h0000_0001};
        vt[3] = '{32'hFFFF_FF00, 1'b1, 8'h00, 32'h0001_0101, 32'h0000_0101};
        vt[4] = '{32'h0000_FEFF, 1'b1, 8'hFF, 32'h0001_0001, 32'h0000_0001};
        vt[5] = '{32'h1234_5CFF, 1'b0, 8'h00, 32'h0000_0000, 32'h0000_0000};
        vt[6] = '{32'h0000_0107, 1'b1, 8'h07, 32'h0001_0101, 32'h0000_0101};

        // reset state and quiet line
        reset = 1'b1;
        command = '0;
        repeat (3) tick();
        chk("reset_status", status, 32'h0);
        chk("reset_txd", 32'(txd), 32'd1);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (status !== 32'h0 || txd !== 1'b1) bad++;
        end
        chk("idle_100_bad_cycles", 32'(bad), 32'd0);
        chk("idle_no_frame", 32'(rx_q.size()), 32'd0);

        // single-command vectors
        for (int i = 0; i < 7; i++) begin
            rx_q.delete();
            command = vt[i].cmd;
            tick();
            chk("vec_status_ack", status, vt[i].st_ack);
            tick();
            chk("vec_status_pop", status, vt[i].st_pop);
            if (vt[i].send) begin
                chk("vec_txd_start", 32'(txd), 32'd0);
                n = 1;
                while (status[0] === 1'b1 && n < 200) begin
                    tick();
                    n++;
                end
                chk("vec_busy_len", 32'(n), 32'(FLEN + 1));
            end else begin
                bad = 0;
                for (int k = 0; k < FLEN + 5; k++) begin
                    tick();
                    if (txd !== 1'b1 || status[0] !== 1'b0) bad++;
                end
                chk("vec_no_send_bad_cycles", 32'(bad), 32'd0);
            end
            chk("vec_rx_count", 32'(rx_q.size()), 32'(vt[i].send));
            if (vt[i].send && rx_q.size() > 0)
                chk("vec_rx_byte", 32'(rx_q[0]), 32'(vt[i].data));
        end
        tog = 1'b1;

        // back-to-back burst that overfills the FIFO
        rx_q.delete();
        gap_q.delete();
        for (int k = 0; k < 6; k++) begin
            send_byte(8'(8'h10 + k), 23'h0, waits[k]);
            st[k] = status;
        end
        for (int k = 0; k < 5; k++)
            chk("burst_ack_wait", 32'(waits[k]), 32'd1);
        chk("burst_full_status", st[4], 32'h0004_0003 | {23'h0, ~tog, 8'h0});
        chk("burst_6th_wait", 32'(waits[5]), 32'(FLEN - 1));
        chk("burst_6th_count", 32'(st[5][23:16]), 32'd4);
        chk("burst_6th_full", 32'(st[5][1]), 32'd1);
        drain(6 * FLEN + 100);
        repeat (2) tick();
        chk("burst_rx_count", 32'(rx_q.size()), 32'd6);
        for (int k = 0; k < 6 && k < rx_q.size(); k++)
            chk("burst_rx_byte", 32'(rx_q[k]), 32'(8'h10 + k));
        for (int k = 1; k < 6 && k < gap_q.size(); k++)
            chk("burst_gap", 32'(gap_q[k]), 32'd1);

        // same toggle rewrite never sends
        rx_q.delete();
        command = {23'h0, tog, 8'h55};
        repeat (FLEN + 10) tick();
        chk("rewrite_rx_count", 32'(rx_q.size()), 32'd0);
        chk("rewrite_status", status, {23'h0, tog, 8'h0});

        // reset during DATA bit 3, command[8] held at 1
        if (tog) begin
            send_byte(8'h3C, 23'h0, n);
            drain(FLEN + 50);
            repeat (2) tick();
        end
        rx_q.delete();
        send_byte(8'hA5, 23'h0, n);
        repeat (18) tick();
        chk("pre_reset_bit3", 32'(txd), 32'd0);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_reset_txd", 32'(txd), 32'd1);
        chk("mid_reset_status", status, 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        n = 0;
        while (status[8] !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("post_reset_ack", 32'(status[8]), 32'd1);
        drain(FLEN + 50);
        repeat (FLEN + 10) tick();
        chk("post_reset_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0)
            chk("post_reset_rx_byte", 32'(rx_q[0]), 32'h0000_00A5);

        // randomized writes against the toggle protocol model
        rx_q.delete();
        exp_q.delete();
        for (int r = 0; r < 40; r++) begin
            d = 8'($urandom);
            up = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                send_byte(d, up[22:0], n);
                exp_q.push_back(d);
            end else begin
                command = {up[22:0], tog, d};
            end
            repeat ($urandom_range(0, 30)) tick();
        end
        drain(40 * (FLEN + 2) + 200);
        repeat (4) tick();
        chk("rand_rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
            chk("rand_rx_byte", 32'(rx_q[k]), 32'(exp_q[k]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
